// File: rtl/fft_input_framer_if.sv
// Stream bundle for the FFT input framer.
//   s_data/s_valid/s_sof/s_ready : serial sample stream into the framer
//   m_data/m_valid/m_ready       : parallel frame stream out of the framer
// Modports:
//   slave  : the framer (consumes samples, produces frames)
//   master : the environment (sample source and frame sink)
interface fft_input_framer_if #(
    parameter int DATA_W = 8,
    parameter int N      = 8
);
    logic [DATA_W-1:0]   s_data;
    logic                s_valid;
    logic                s_sof;
    logic                s_ready;
    logic [N*DATA_W-1:0] m_data;
    logic                m_valid;
    logic                m_ready;

    modport slave (
        input  s_data, s_valid, s_sof, m_ready,
        output s_ready, m_data, m_valid
    );

    modport master (
        output s_data, s_valid, s_sof, m_ready,
        input  s_ready, m_data, m_valid
    );
endinterface

// File: rtl/fft_input_framer.sv
// Serial-to-parallel input framer with ping-pong frame buffers.
// Packs every N accepted samples into one parallel frame (sample k at
// bits [k*DATA_W +: DATA_W]). One bank fills while the other waits for
// the downstream decimation stage.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   bus      : sample/frame streams (slave modport)
//   sof_err  : one-cycle pulse after an s_sof that arrived mid-frame
//   drop_cnt : number of discarded partial frames, saturating at 255
module fft_input_framer #(
    parameter int DATA_W = 8,
    parameter int N      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fft_input_framer_if.slave   bus,
    output logic                sof_err,
    output logic [7:0]          drop_cnt
);
    localparam int CNT_W = $clog2(N);

    logic [N*DATA_W-1:0] bank [2];
    logic [1:0]          full;
    logic [1:0]          full_nxt;
    logic                wr_bank;
    logic                rd_bank;
    logic [CNT_W-1:0]    wr_cnt;

    logic                accept;
    logic                resync;
    logic                wr_done;
    logic                rd_fire;
    logic [CNT_W-1:0]    wr_idx;

    // s_ready depends only on registers and rst_n, never on s_valid.
    assign bus.s_ready = rst_n & ~full[wr_bank];
    assign accept      = bus.s_valid & bus.s_ready;

    // A start-of-frame mid-frame restarts the frame at index 0; the
    // stale entries of the partial frame are simply overwritten later.
    assign resync  = accept & bus.s_sof & (wr_cnt != '0);
    assign wr_idx  = resync ? '0 : wr_cnt;
    assign wr_done = accept & (wr_idx == CNT_W'(N - 1));

    assign bus.m_valid = full[rd_bank];
    assign bus.m_data  = bank[rd_bank];
    assign rd_fire     = full[rd_bank] & bus.m_ready;

    // Fill and drain can never target the same bank in one cycle: a bank
    // being filled is empty, a bank being read is full.
    always_comb begin
        full_nxt = full;
        if (rd_fire) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank[0]  <= '0;
            bank[1]  <= '0;
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            sof_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                bank[wr_bank][int'(wr_idx) * DATA_W +: DATA_W] <= bus.s_data;
                if (wr_done) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt  <= wr_idx + 1'b1;
                end
            end
            if (rd_fire) begin
                rd_bank <= ~rd_bank;
            end
            full    <= full_nxt;
            sof_err <= resync;
            if (resync && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_fft_input_framer.sv
// Testbench for fft_input_framer: directed scenarios followed by a long
// randomized run. A reference model builds expected frames from the
// accepted samples; a monitor compares frames, sof_err pulses and
// output stability against it.
module tb_fft_input_framer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sof_err;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    fft_input_framer_if #(.DATA_W(8), .N(8)) bus ();

    fft_input_framer #(.DATA_W(8), .N(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .sof_err  (sof_err),
        .drop_cnt (drop_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_drops = 0;
    int          frames_pushed = 0;
    int          frames_popped = 0;
    logic [63:0] sb [$];
    logic [7:0]  cur [$];
    int          sof_cyc [$];
    bit          rand_mode = 0;
    bit          held = 0;
    bit          exp_sof;
    logic [63:0] held_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the frame is just the list of samples since the
    // last completed frame; a mid-frame SOF throws that list away.
    task automatic model_accept(input logic [7:0] d, input logic sof);
        logic [63:0] f;
        if (sof && cur.size() != 0) begin
            cur.delete();
            if (exp_drops < 255) exp_drops++;
            sof_cyc.push_back(cyc + 1);
        end
        cur.push_back(d);
        if (cur.size() == 8) begin
            f = '0;
            for (int k = 0; k < 8; k++) f[k*8 +: 8] = cur[k];
            sb.push_back(f);
            cur.delete();
            frames_pushed++;
        end
    endtask

    task automatic model_reset();
        cur.delete();
        sb.delete();
        sof_cyc.delete();
        exp_drops = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic sof, input bit exp_ready);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_sof   = sof;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_ready && t == 0) chk("s_ready_stream", bus.s_ready, 1);
            if (bus.s_ready) begin
                model_accept(d, sof);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: s_ready stayed %b, required 1 within 200 cycles", bus.s_ready);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    // Monitor: sampled on the falling edge, between active edges.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_sof = (sof_cyc.size() != 0) && (sof_cyc[0] == cyc);
                if (exp_sof) void'(sof_cyc.pop_front());
                chk("sof_err", sof_err, exp_sof);
                if (held && bus.m_valid) chk("m_data_hold", bus.m_data, held_data);
                if (bus.m_valid && bus.m_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %h required no frame", bus.m_data);
                    end else begin
                        chk("frame", bus.m_data, sb.pop_front());
                        frames_popped++;
                    end
                end
                held      = bus.m_valid && !bus.m_ready;
                held_data = bus.m_data;
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) bus.m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_sof   = 1'b0;
        bus.m_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_s_ready", bus.s_ready, 0);
        chk("reset_m_valid", bus.m_valid, 0);
        chk("reset_m_data", bus.m_data, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        chk("reset_sof_err", sof_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("s_ready_after_reset", bus.s_ready, 1);

        // First frame and latency
        for (int i = 1; i <= 8; i++) send(8'(i), (i == 1), 1);
        chk("latency_pre", bus.m_valid, 0);
        idle();
        @(negedge clk);
        chk("latency_m_valid", bus.m_valid, 1);
        chk("frame1_data", bus.m_data, 64'h0807060504030201);

        // Continuous stream of three frames
        for (int i = 0; i < 24; i++) send(8'(i), (i % 8 == 0), 1);
        idle();
        repeat (2) @(negedge clk);
        chk("stream_frames", frames_popped, 4);

        // Backpressure: both banks fill, input stalls
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i), 0, 1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd16;
        bus.s_sof   = 1'b0;
        @(negedge clk);
        chk("full_s_ready", bus.s_ready, 0);
        chk("full_m_valid", bus.m_valid, 1);
        chk("full_m_data", bus.m_data, 64'h0706050403020100);
        repeat (3) @(negedge clk);
        chk("stall_m_data", bus.m_data, 64'h0706050403020100);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("stall_until_handshake", bus.s_ready, 0);
        @(negedge clk);
        chk("s_ready_returns", bus.s_ready, 1);
        chk("frame2_valid", bus.m_valid, 1);
        chk("frame2_data", bus.m_data, 64'h0f0e0d0c0b0a0908);
        model_accept(8'd16, 1'b0);
        for (int i = 17; i < 24; i++) send(8'(i), 0, 1);
        idle();
        repeat (2) @(negedge clk);

        // SOF resync
        send(8'h11, 1, 1);
        send(8'h12, 0, 1);
        send(8'h13, 0, 1);
        send(8'hAA, 1, 1);
        for (int i = 1; i <= 7; i++) send(8'(i), 0, 1);
        idle();
        @(negedge clk);
        chk("sof_frame_valid", bus.m_valid, 1);
        chk("sof_frame_data", bus.m_data, 64'h07060504030201AA);
        chk("sof_drop_cnt", drop_cnt, 1);

        // Reset mid-frame
        for (int i = 0; i < 5; i++) send(8'(8'h30 + i), (i == 0), 1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_m_valid", bus.m_valid, 0);
        chk("midreset_drop_cnt", drop_cnt, 0);
        chk("midreset_s_ready", bus.s_ready, 1);
        for (int i = 0; i < 8; i++) send(8'(8'h40 + i), 0, 1);
        idle();
        @(negedge clk);
        chk("post_reset_frame", bus.m_data, 64'h4746454443424140);
        repeat (2) @(negedge clk);

        // Randomized traffic over 1000 completed frames
        base = frames_pushed;
        rand_mode = 1;
        n = 0;
        while (frames_pushed < base + 1000 && n < 40000) begin
            if ($urandom_range(0, 3) == 0) idle();
            else send(8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0), 0);
            n++;
        end
        idle();
        @(posedge clk);
        #1;
        rand_mode = 0;
        bus.m_ready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("random_frame_count", frames_pushed - base, 1000);
        chk("drain_empty", sb.size(), 0);
        chk("random_drop_cnt", drop_cnt, exp_drops);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_input_framer.md
# fft_input_framer

Serial-to-parallel input framer for the radix-2 pipelined FFT. It accepts time-domain samples one per cycle over a valid/ready stream and packs each group of 8 into a parallel frame. It presents that frame to the even/odd decimation stage, which splits 8 into two groups of 4. Two frame buffers (ping-pong) let the next frame fill while the current one waits for the downstream stage.

## Interface
- DATA_W, 8, sample width in bits
- N, 8, samples per frame; fixed at 8 for this FFT size; counter width 3 bits

- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  reset, synchronous, active-low
- s_data  in  DATA_W  input sample
- s_valid  in  1  s_data valid
- s_sof  in  1  start-of-frame marker, qualified by s_valid
- s_ready  out  1  framer can accept a sample this cycle
- m_data  out  N*DATA_W  frame; sample k (k-th accepted, k=0 first) at bits [k*DATA_W +: DATA_W]
- m_valid  out  1  m_data holds a complete frame
- m_ready  in  1  downstream accepts the frame
- sof_err  out  1  one-cycle pulse when s_sof arrives mid-frame
- drop_cnt  out  8  count of partial frames discarded, saturates at 255

## Operation
- State: bank0/bank1 (N×DATA_W each), full[1:0], wr_bank, rd_bank, wr_cnt[2:0].
- Reset while rst_n=0 at a clk edge:
  - wr_cnt=0, wr_bank=0, rd_bank=0, full=00
  - both banks cleared to 0, so m_data=0
  - m_valid=0, sof_err=0, drop_cnt=0
  - s_ready is forced 0 while rst_n=0.
- s_ready = rst_n & ~full[wr_bank]. This is combinational from registers only; it has no path from s_valid.
- Accept = s_valid & s_ready.
  - On accept, write s_data to bank[wr_bank][wr_cnt] and increment wr_cnt.
  - If the written index is N-1: set full[wr_bank]=1, toggle wr_bank, set wr_cnt=0.
- SOF resync: on accept with s_sof=1 and wr_cnt≠0:
  - Discard the partial frame. Write the sample at index 0 and set wr_cnt=1.
  - Pulse sof_err next cycle. Increment drop_cnt, saturating at 255.
  - s_sof with wr_cnt=0 is normal. s_sof is never required; a free-running count is legal.
- Output: m_valid = full[rd_bank]; m_data = bank[rd_bank], registered contents.
  - On m_valid & m_ready: clear full[rd_bank] and toggle rd_bank.
  - m_data must stay stable while m_valid=1 and m_ready=0.
- Simultaneous write-complete and read-handshake in one cycle: they always target different banks. Both take effect, and neither is lost.
- Both banks full: s_ready=0. Input stalls until a frame is consumed. s_ready rises the cycle after the handshake.
- Samples without s_valid are ignored. No reordering is done here; the downstream stage does the even/odd split.

## Timing
- Latency: m_valid rises on the cycle after the clk edge that accepts the 8th sample of a frame.
- Throughput: 1 sample/cycle sustained, provided each frame is consumed within 8 cycles of m_valid.
- s_ready falls the cycle after the second bank fills, while the first is still unconsumed.
- sof_err is registered: high exactly one cycle, the cycle after the offending accept.
- Reset mid-frame or mid-handshake: every pending frame is discarded. m_valid=0 on the cycle after the reset edge, and the next accepted sample is index 0.

## Test plan
- Reset, then stream 0x01..0x08 with m_ready=1:
  - m_valid is high one cycle after 0x08 is accepted.
  - m_data = 0x0807060504030201.
  - s_ready stays 1 throughout.
- Continuous stream 0x00..0x17 with m_ready=1: three frames, 0x07..00, 0x0F..08, 0x17..10, each one cycle after completion; no s_ready deassertion.
- m_ready=0, stream 20 samples:
  - s_ready drops after sample 16.
  - m_data holds 0x0706050403020100 stable.
  - Raise m_ready: second frame 0x0F..08 follows, and s_ready returns the next cycle.
- Send 3 samples, then a sample 0xAA with s_sof=1, then 7 more (0x01..0x07):
  - sof_err pulses once and drop_cnt=1.
  - The frame is 0x07060504030201AA.
- Assert rst_n=0 for one cycle after 5 samples: m_valid=0, drop_cnt=0, and the following 8 samples form a clean frame.
- Randomised s_valid/m_ready over 1000 frames: every frame matches the scoreboard in order, with no loss or duplication.
